// File: rtl/regfile_2r1w.sv
// 32x64 architectural register file: one synchronous write port, two combinational read ports, index 31 reads as zero.
// Write lands one edge later, reads have zero latency with same-cycle write bypass, and the block never stalls its requesters.
module regfile_2r1w #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             write_enable,
  input  logic [4:0]       write_addr,
  input  logic [WIDTH-1:0] write_data,
  input  logic [4:0]       read_addr_a,
  output logic [WIDTH-1:0] read_data_a,
  input  logic [4:0]       read_addr_b,
  output logic [WIDTH-1:0] read_data_b
);

  localparam logic [4:0] ZERO_IDX = 5'(DEPTH - 1);

  // No storage exists for the zero register.
  logic [WIDTH-1:0] mem [0:DEPTH-2];

  logic do_write;
  assign do_write = reset && write_enable && (write_addr != ZERO_IDX);

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        mem[i] <= '0;
      end
    end else if (do_write) begin
      mem[write_addr] <= write_data;
    end
  end

  // Bypass is gated by reset so reads show pre-edge contents while reset is held.
  always_comb begin
    read_data_a = '0;
    if (read_addr_a == ZERO_IDX) begin
      read_data_a = '0;
    end else if (reset && write_enable && (write_addr == read_addr_a)) begin
      read_data_a = write_data;
    end else begin
      read_data_a = mem[read_addr_a];
    end
  end

  always_comb begin
    read_data_b = '0;
    if (read_addr_b == ZERO_IDX) begin
      read_data_b = '0;
    end else if (reset && write_enable && (write_addr == read_addr_b)) begin
      read_data_b = write_data;
    end else begin
      read_data_b = mem[read_addr_b];
    end
  end

endmodule
